// File: rtl/vector_check_seq_if.sv
// rtl/vector_check_seq_if.sv - vector ROM and operator handshake bundle for vector_check_seq
interface vector_check_seq_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) ();
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ce;
  logic [DATA_W-1:0] rom_a;
  logic [DATA_W-1:0] rom_b;
  logic [DATA_W-1:0] rom_z;
  logic              op_start;
  logic              op_ready;
  logic              op_done;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_sign;
  logic [DATA_W-1:0] op_result;

  modport master (
    output rom_addr, rom_ce,
    input  rom_a, rom_b, rom_z,
    output op_start, op_a, op_b, op_sign,
    input  op_ready, op_done, op_result
  );

  modport slave (
    input  rom_addr, rom_ce,
    output rom_a, rom_b, rom_z,
    input  op_start, op_a, op_b, op_sign,
    output op_ready, op_done, op_result
  );
endinterface

// File: rtl/vector_check_seq.sv
// rtl/vector_check_seq.sv - self-checking vector sequencer driving one operator core under ap_* control
// Optional VCS_FIRST_FAIL_EN adds fail_idx/fail_vld reporting the first mismatching vector of a run.
module vector_check_seq #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 22,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8,
  parameter int TMO_W  = 12
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               ap_start,
  output logic               ap_done,
  output logic               ap_idle,
  output logic               ap_ready,
  output logic [CNT_W-1:0]   ap_return,
`ifdef VCS_FIRST_FAIL_EN
  output logic [ADDR_W-1:0]  fail_idx,
  output logic               fail_vld,
`endif
  vector_check_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_LAUNCH, S_WAIT, S_CHECK
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [TMO_W-1:0]  TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] op_a_r, op_b_r, z_reg, res_reg;
  logic              op_sign_r;
  logic [TMO_W-1:0]  wdog;
  logic              tmo_flag;
  logic              bypass, tmo_hit, mismatch;

  assign bypass   = bus.rom_a[DATA_W-1] ^ bus.rom_b[DATA_W-1];
  // The WAIT cycle that would carry the watchdog to all-ones is the last one allowed.
  assign tmo_hit  = (wdog == TMO_LAST);
  assign mismatch = tmo_flag | (res_reg != z_reg);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (ap_start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = (idx == LAST_IDX) ? S_IDLE : S_LOAD;
      S_LOAD:   state_nxt = bypass ? S_CHECK : S_LAUNCH;
      S_LAUNCH: if (bus.op_ready) state_nxt = S_WAIT;
      S_WAIT:   if (bus.op_done || tmo_hit) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ap_done      = (state == S_FETCH) && (idx == LAST_IDX);
    ap_ready     = ap_done;
    ap_idle      = (state == S_IDLE) && !ap_start;
    bus.rom_ce   = (state == S_FETCH) && (idx != LAST_IDX);
    bus.rom_addr = idx;
    bus.op_start = (state == S_LAUNCH);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      idx       <= '0;
      cnt       <= '0;
      op_a_r    <= '0;
      op_b_r    <= '0;
      op_sign_r <= 1'b0;
      z_reg     <= '0;
      res_reg   <= '0;
      wdog      <= '0;
      tmo_flag  <= 1'b0;
`ifdef VCS_FIRST_FAIL_EN
      fail_idx  <= '0;
      fail_vld  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (ap_start) begin
          idx      <= '0;
          cnt      <= '0;
`ifdef VCS_FIRST_FAIL_EN
          fail_idx <= '0;
          fail_vld <= 1'b0;
`endif
        end
        S_LOAD: begin
          op_a_r    <= bus.rom_a;
          op_b_r    <= bus.rom_b;
          op_sign_r <= bus.rom_a[DATA_W-1];
          z_reg     <= bus.rom_z;
          tmo_flag  <= 1'b0;
        end
        S_LAUNCH: wdog <= '0;
        // A result arriving on the timeout cycle still counts as a normal completion.
        S_WAIT: begin
          if (bus.op_done)  res_reg  <= bus.op_result;
          else if (tmo_hit) tmo_flag <= 1'b1;
          else              wdog     <= wdog + 1'b1;
        end
        S_CHECK: begin
          idx <= idx + 1'b1;
          if (mismatch && (cnt != CNT_MAX)) cnt <= cnt + 1'b1;
`ifdef VCS_FIRST_FAIL_EN
          if (mismatch && !fail_vld) begin
            fail_idx <= idx;
            fail_vld <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign ap_return   = cnt;
  assign bus.op_a    = op_a_r;
  assign bus.op_b    = op_b_r;
  assign bus.op_sign = op_sign_r;

endmodule

// File: tb/tb_vector_check_seq.sv
// tb/tb_vector_check_seq.sv - randomized scoreboard bench for vector_check_seq
module tb_vector_check_seq;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 22;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 2;
  localparam int TMO_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic ap_clk = 1'b0;
  logic ap_rst_n, ap_start;
  logic ap_done, ap_idle, ap_ready;
  logic [CNT_W-1:0] ap_return;
`ifdef VCS_FIRST_FAIL_EN
  logic [ADDR_W-1:0] fail_idx;
  logic              fail_vld;
`endif

  vector_check_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  vector_check_seq #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TMO_W(TMO_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_return(ap_return),
`ifdef VCS_FIRST_FAIL_EN
    .fail_idx(fail_idx), .fail_vld(fail_vld),
`endif
    .bus(bus)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct { int idx; logic [63:0] a; logic [63:0] b; } launch_t;
  typedef struct { int ret; bit fv; int fi; } run_t;

  logic [63:0] va [32];
  logic [63:0] vb [32];
  logic [63:0] vz [32];
  bit          corrupt [32];
  bit          hang [32];
  launch_t     lq [$];
  run_t        rq [$];
  logic [63:0] model_res;
  int          total = 0;
  int          bad = 0;
  int          dones = 0;
  int          fixed_lat = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(posedge ap_clk) begin
    if (bus.rom_ce) begin
      bus.rom_a <= va[bus.rom_addr];
      bus.rom_b <= vb[bus.rom_addr];
      bus.rom_z <= vz[bus.rom_addr];
    end
  end

  // Operator: random ready delay, random latency, optional corruption or hang per vector.
  initial begin : operator
    bit job = 0, seen = 0, cur_hang = 0;
    int rw = 0, lat = 0;
    logic [63:0] cur_res = '0;
    launch_t it;
    bus.op_ready = 1'b0; bus.op_done = 1'b0; bus.op_result = '0;
    forever begin
      @(negedge ap_clk);
      bus.op_ready = 1'b0;
      bus.op_done  = 1'b0;
      if (!ap_rst_n) begin
        job = 0; seen = 0;
      end else if (job) begin
        lat--;
        if (lat == 0) begin
          job = 0;
          if (!cur_hang) begin bus.op_done = 1'b1; bus.op_result = cur_res; end
        end
      end else if (bus.op_start) begin
        if (!seen) begin seen = 1; rw = $urandom_range(0, 2); end
        if (rw > 0) rw--;
        else begin
          bus.op_ready = 1'b1; seen = 0; job = 1;
          lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 5);
          if (lq.size() == 0) begin
            total++; bad++;
            $display("FAIL launch: unexpected op_start idx %0d", bus.rom_addr);
            cur_hang = 0; cur_res = '0;
          end else begin
            it = lq.pop_front();
            chk($sformatf("op_a[%0d]", it.idx), bus.op_a, it.a);
            chk($sformatf("op_b[%0d]", it.idx), bus.op_b, it.b);
            chk($sformatf("op_sign[%0d]", it.idx), 64'(bus.op_sign), 64'(it.a[63]));
            cur_hang = hang[it.idx];
            cur_res  = (it.a - it.b) ^ 64'(corrupt[it.idx]);
          end
        end
      end
    end
  end

  initial begin : monitor
    run_t r;
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n && ap_done) begin
        dones++;
        chk("ap_ready", 64'(ap_ready), 64'd1);
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL done: unexpected ap_done ret %0d", ap_return);
        end else begin
          r = rq.pop_front();
          chk("ap_return", 64'(ap_return), 64'(r.ret));
`ifdef VCS_FIRST_FAIL_EN
          chk("fail_vld", 64'(fail_vld), 64'(r.fv));
          if (r.fv) chk("fail_idx", 64'(fail_idx), 64'(r.fi));
`endif
        end
      end
    end
  end

  // Reference: walk the vector table, reuse the last result for sign-mismatched pairs.
  task automatic push_expect();
    run_t r;
    logic [63:0] res = model_res;
    int c = 0;
    bit m;
    r.fv = 0; r.fi = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (va[i][63] != vb[i][63]) m = (res != vz[i]);
      else begin
        launch_t l;
        l.idx = i; l.a = va[i]; l.b = vb[i];
        lq.push_back(l);
        if (hang[i]) m = 1;
        else begin
          res = (va[i] - vb[i]) ^ 64'(corrupt[i]);
          m = (res != vz[i]);
        end
      end
      if (m) begin
        if (c < CMAX) c++;
        if (!r.fv) begin r.fv = 1; r.fi = i; end
      end
    end
    model_res = res;
    r.ret = c;
    rq.push_back(r);
  endtask

  task automatic gen(input int p_byp, input int p_cor, input int p_hang);
    for (int i = 0; i < 32; i++) begin
      va[i] = {$urandom, $urandom};
      vb[i] = {$urandom, $urandom};
      vb[i][63] = va[i][63];
      if ($urandom_range(0, 99) < p_byp) vb[i][63] = ~va[i][63];
      vz[i] = va[i] - vb[i];
      corrupt[i] = ($urandom_range(0, 99) < p_cor);
      hang[i]    = ($urandom_range(0, 99) < p_hang);
    end
  endtask

  task automatic wait_dones(input int target, input string nm);
    int n = 0;
    while (dones < target && n < 5000) begin
      @(negedge ap_clk);
      n++;
    end
    if (dones < target) begin
      total++; bad++;
      $display("FAIL %s: timeout dones=%0d want %0d", nm, dones, target);
    end
  endtask

  task automatic run_once(input string nm);
    int d0 = dones;
    push_expect();
    @(negedge ap_clk); ap_start = 1'b1;
    @(negedge ap_clk); ap_start = 1'b0;
    wait_dones(d0 + 1, nm);
    chk({nm, "_launch_left"}, 64'(lq.size()), 64'd0);
  endtask

  initial begin : main
    int d0, n;
    ap_rst_n = 1'b0; ap_start = 1'b0; model_res = '0;
    gen(0, 0, 0);
    repeat (3) @(negedge ap_clk);
    chk("rst_idle", 64'(ap_idle), 64'd1);
    chk("rst_done", 64'(ap_done), 64'd0);
    chk("rst_return", 64'(ap_return), 64'd0);
    chk("rst_op_start", 64'(bus.op_start), 64'd0);
    chk("rst_rom_ce", 64'(bus.rom_ce), 64'd0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    // Golden run, fixed latency 3, with a stray start while busy.
    fixed_lat = 3;
    gen(0, 0, 0);
    d0 = dones;
    push_expect();
    @(negedge ap_clk); ap_start = 1'b1;
    @(negedge ap_clk); ap_start = 1'b0;
    repeat (15) @(negedge ap_clk);
    ap_start = 1'b1;
    @(negedge ap_clk); ap_start = 1'b0;
    wait_dones(d0 + 1, "golden");
    repeat (10) @(negedge ap_clk);
    chk("golden_single_done", 64'(dones), 64'(d0 + 1));
    chk("golden_idle", 64'(ap_idle), 64'd1);
    fixed_lat = 0;

    gen(0, 0, 0);
    corrupt[3] = 1; corrupt[17] = 1;
    run_once("corrupt");

    // Abort mid-WAIT on vector 2 after two counted mismatches.
    fixed_lat = 4;
    gen(0, 0, 0);
    corrupt[0] = 1; corrupt[1] = 1;
    push_expect();
    @(negedge ap_clk); ap_start = 1'b1;
    @(negedge ap_clk); ap_start = 1'b0;
    n = 0;
    while (lq.size() > DEPTH - 3 && n < 2000) begin @(negedge ap_clk); n++; end
    chk("rstmid_reached", 64'(lq.size() <= DEPTH - 3), 64'd1);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b0;
    #1;
    chk("rstmid_op_start", 64'(bus.op_start), 64'd0);
    chk("rstmid_return", 64'(ap_return), 64'd0);
    chk("rstmid_idle", 64'(ap_idle), 64'd1);
    chk("rstmid_done", 64'(ap_done), 64'd0);
    repeat (2) @(negedge ap_clk);
    lq.delete(); rq.delete(); model_res = '0;
    ap_rst_n = 1'b1;
    fixed_lat = 0;
    @(negedge ap_clk);

    // Bypass on vector 0 (compares with reset result 0) and vector 5 (reuses vector 4).
    gen(0, 0, 0);
    vb[0][63] = ~va[0][63]; vz[0] = '0;
    vb[5][63] = ~va[5][63]; vz[5] = va[4] - vb[4];
    run_once("bypass");

    gen(0, 0, 0);
    hang[0] = 1;
    run_once("timeout");

    gen(0, 0, 0);
    corrupt[1] = 1; corrupt[4] = 1; corrupt[8] = 1;
    corrupt[12] = 1; corrupt[15] = 1; corrupt[21] = 1;
    run_once("saturate");

    // Back-to-back runs with ap_start held high across done.
    gen(0, 0, 0);
    corrupt[2] = 1; corrupt[9] = 1;
    d0 = dones;
    push_expect();
    push_expect();
    @(negedge ap_clk); ap_start = 1'b1;
    wait_dones(d0 + 1, "b2b_first");
    repeat (3) @(negedge ap_clk);
    ap_start = 1'b0;
    wait_dones(d0 + 2, "b2b_second");
    chk("b2b_launch_left", 64'(lq.size()), 64'd0);

    for (int k = 0; k < 6; k++) begin
      gen(12, 5, 3);
      run_once($sformatf("rand%0d", k));
    end

    repeat (5) @(negedge ap_clk);
    chk("final_rq_empty", 64'(rq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
